// File: rtl/filter_pkg.sv
// Shared widths and sample types for the filter datapath and its output-side requantiser.
package filter_pkg;
    localparam int IN_W  = 36;
    localparam int OUT_W = 19;
    localparam int SHIFT = 17;

    typedef logic signed [IN_W-1:0]  acc_t;
    typedef logic signed [OUT_W-1:0] sample_t;
endpackage

// File: rtl/filter_sync_fifo.sv
// Single-clock FIFO with show-ahead head; reads as zero while empty.
module filter_sync_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/filter_requant_sink.sv
// Rounds and saturates the full-precision filter result to the sample format, then buffers it
// for a valid/ready consumer while tracking sticky saturation/overflow status and a write count.
module filter_requant_sink #(
    parameter int IN_W  = filter_pkg::IN_W,
    parameter int OUT_W = filter_pkg::OUT_W,
    parameter int SHIFT = filter_pkg::SHIFT,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [IN_W-1:0]   FilterOut,
    input  logic                     FilterValid,
    input  logic                     ReadyIn,
    output logic signed [OUT_W-1:0]  SampleOut,
    output logic                     ValidOut,
    input  logic                     clr,
    output logic                     sat_flag,
    output logic                     ovf_flag,
    output logic [15:0]              sample_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) <<< (SHIFT-1);
    localparam logic signed [IN_W:0] QMAX = (IN_W+1)'((1 <<< (OUT_W-1)) - 1);
    localparam logic signed [IN_W:0] QMIN = (IN_W+1)'(-(1 <<< (OUT_W-1)));

    function automatic logic signed [IN_W:0] round_half_up(input logic signed [IN_W-1:0] x);
        return $signed({x[IN_W-1], x}) + HALF;
    endfunction

    // Returns {saturated, sample}.
    function automatic logic [OUT_W:0] saturate(input logic signed [IN_W:0] sum);
        logic signed [IN_W:0] q;
        q = sum >>> SHIFT;
        if (q > QMAX)      return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        else if (q < QMIN) return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        else               return {1'b0, q[OUT_W-1:0]};
    endfunction

    logic signed [IN_W:0]  sum_p1;
    logic                  vld_p1;
    logic signed [OUT_W-1:0] q_p2;
    logic                  sat_p2;
    logic                  vld_p2;

    logic [OUT_W-1:0]      fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic                  pop;
    logic                  wr_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= FilterValid;
            vld_p2 <= vld_p1;
        end
    end

    // Stage 1: add the rounding half-LSB at one extra bit of headroom.
    always_ff @(posedge clk) begin
        sum_p1 <= round_half_up(FilterOut);
    end

    // Stage 2: drop SHIFT LSBs and clamp into the sample range.
    always_ff @(posedge clk) begin
        {sat_p2, q_p2} <= saturate(sum_p1);
    end

    assign ValidOut  = (fifo_count != '0);
    assign pop       = ReadyIn && !fifo_empty;
    assign wr_en     = vld_p2 && (!fifo_full || pop);
    assign SampleOut = fifo_rdata;

    filter_sync_fifo #(
        .WIDTH(OUT_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_en),
        .pop   (pop),
        .wdata (q_p2),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Status follows the FIFO write edge; a clear in the same cycle overrides any update.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            sat_flag   <= 1'b0;
            ovf_flag   <= 1'b0;
            sample_cnt <= '0;
        end else begin
            if (wr_en) begin
                sample_cnt <= sample_cnt + 16'd1;
                if (sat_p2) sat_flag <= 1'b1;
            end
            if (vld_p2 && !wr_en) ovf_flag <= 1'b1;
        end
    end
endmodule

// File: tb/tb_filter_requant_sink.sv
// Directed bench for filter_requant_sink: queue-based reference model plus literal expectations.
module tb_filter_requant_sink;
    import filter_pkg::*;

    localparam int DEPTH = 8;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic signed [IN_W-1:0]  FilterOut = '0;
    logic                    FilterValid = 1'b0;
    logic                    ReadyIn = 1'b0;
    logic                    clr = 1'b0;
    logic signed [OUT_W-1:0] SampleOut;
    logic                    ValidOut;
    logic                    sat_flag;
    logic                    ovf_flag;
    logic [15:0]             sample_cnt;

    always #5 clk = ~clk;

    filter_requant_sink #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .FilterOut(FilterOut), .FilterValid(FilterValid),
        .ReadyIn(ReadyIn), .SampleOut(SampleOut), .ValidOut(ValidOut), .clr(clr),
        .sat_flag(sat_flag), .ovf_flag(ovf_flag), .sample_cnt(sample_cnt)
    );

    // Reference model: two-deep delay line, a queue for the buffer, plain status variables.
    int  m_q[$];
    bit  p1_v, p2_v, p1_s, p2_s;
    int  p1_d, p2_d;
    bit  m_sat, m_ovf;
    int  m_cnt;
    bit  chk_en = 1'b0;
    int  total = 0;
    int  passed = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic void model_req(input longint x, output int v, output bit s);
        longint q;
        longint hi;
        hi = (64'sd1 <<< (OUT_W-1)) - 1;
        q  = (x + (64'sd1 <<< (SHIFT-1))) >>> SHIFT;
        s  = 1'b0;
        if (q > hi) begin
            q = hi; s = 1'b1;
        end else if (q < -hi - 1) begin
            q = -hi - 1; s = 1'b1;
        end
        v = int'(q);
    endfunction

    task automatic step();
        bit pop;
        bit acc;
        pop = (m_q.size() > 0) && ReadyIn;
        acc = p2_v && ((m_q.size() < DEPTH) || pop);
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            p1_v = 0; p2_v = 0;
            m_sat = 0; m_ovf = 0; m_cnt = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(p2_d);
            if (clr) begin
                m_sat = 0; m_ovf = 0; m_cnt = 0;
            end else begin
                if (acc) begin
                    m_cnt = (m_cnt + 1) % 65536;
                    if (p2_s) m_sat = 1;
                end
                if (p2_v && !acc) m_ovf = 1;
            end
            p2_v = p1_v; p2_d = p1_d; p2_s = p1_s;
            p1_v = FilterValid;
            model_req(longint'(FilterOut), p1_d, p1_s);
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input longint x);
        FilterValid = v;
        FilterOut   = IN_W'(x);
        step();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_valid", ValidOut, m_q.size() > 0);
            if (m_q.size() > 0) check("model_sample", SampleOut, m_q[0]);
            check("model_sat", sat_flag, m_sat);
            check("model_ovf", ovf_flag, m_ovf);
            check("model_cnt", sample_cnt, m_cnt);
        end
    end

    longint rv[5] = '{64'sh20000, 64'sh10000, 64'shFFFF, -64'sd65536, -64'sd65537};
    int     re[5] = '{1, 1, 0, 0, -1};

    initial begin
        rst_n = 1'b0;
        step();
        step();
        check("rst_valid", ValidOut, 0);
        check("rst_sample", SampleOut, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_ovf", ovf_flag, 0);
        check("rst_cnt", sample_cnt, 0);
        chk_en  = 1'b1;
        rst_n   = 1'b1;
        ReadyIn = 1'b1;

        // Rounding, back-to-back with ReadyIn high
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, rv[i]);
            if (i >= 2) check("round_out", SampleOut, re[i-2]);
            else        check("round_latency", ValidOut, 0);
        end
        FilterValid = 1'b0;
        for (int i = 3; i < 5; i++) begin
            step();
            check("round_tail", SampleOut, re[i]);
        end
        check("round_cnt", sample_cnt, 5);

        // Saturation and clear
        drive(1'b1, (64'sd1 <<< 35) - 1);
        drive(1'b1, -(64'sd1 <<< 35));
        FilterValid = 1'b0;
        step();
        check("sat_pos", SampleOut, 262143);
        check("sat_flag_set", sat_flag, 1);
        step();
        check("sat_neg", SampleOut, -262144);
        check("sat_flag_kept", sat_flag, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_sat", sat_flag, 0);
        drive(1'b1, -(64'sd1 <<< 35));
        FilterValid = 1'b0;
        step();
        step();
        check("neg_min", SampleOut, -262144);
        check("neg_no_sat", sat_flag, 0);

        // Backpressure and overflow
        clr = 1'b1;
        step();
        clr = 1'b0;
        ReadyIn = 1'b0;
        for (int k = 1; k <= 10; k++) drive(1'b1, longint'(k) <<< 17);
        FilterValid = 1'b0;
        step();
        step();
        check("bp_ovf", ovf_flag, 1);
        check("bp_cnt", sample_cnt, 8);
        ReadyIn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check("bp_drain", SampleOut, k);
            step();
        end
        check("bp_empty", ValidOut, 0);

        // Full FIFO with a simultaneous pop
        clr = 1'b1;
        step();
        clr = 1'b0;
        ReadyIn = 1'b0;
        for (int k = 1; k <= 8; k++) drive(1'b1, longint'(k) <<< 17);
        FilterValid = 1'b0;
        step();
        step();
        check("full_valid", ValidOut, 1);
        drive(1'b1, 64'sd9 <<< 17);
        FilterValid = 1'b0;
        step();
        ReadyIn = 1'b1;
        step();
        check("fullpop_ovf", ovf_flag, 0);
        check("fullpop_cnt", sample_cnt, 9);
        for (int k = 2; k <= 9; k++) begin
            check("fullpop_drain", SampleOut, k);
            step();
        end

        // Reset mid-stream
        ReadyIn = 1'b0;
        for (int k = 1; k <= 5; k++) drive(1'b1, longint'(k) <<< 17);
        FilterValid = 1'b0;
        step();
        step();
        check("pre_rst_valid", ValidOut, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_valid", ValidOut, 0);
        check("mid_rst_sat", sat_flag, 0);
        check("mid_rst_ovf", ovf_flag, 0);
        check("mid_rst_cnt", sample_cnt, 0);
        ReadyIn = 1'b1;
        drive(1'b1, 64'sh40000);
        FilterValid = 1'b0;
        check("post_rst_early", ValidOut, 0);
        step();
        step();
        check("post_rst_valid", ValidOut, 1);
        check("post_rst_sample", SampleOut, 2);

        // Counter wrap
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int n = 0; n < 65537; n++) drive(1'b1, 64'sd0);
        FilterValid = 1'b0;
        step();
        step();
        check("cnt_wrap", sample_cnt, 1);
        step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
